// File: rtl/iec_host_pkg.sv
// Shared types and constants for the host-side IEC byte transmitter.
// Optional TALK turnaround support is enabled by IEC_TURNAROUND_EN.
package iec_host_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ATN_SETUP,
    S_PRESENCE,
    S_READY,
    S_EOI_WAIT,
    S_EOI_ACK,
    S_CLOCKING,
    S_FRAME_ACK,
    S_GAP,
    S_ABORT,
    S_ATN_REL,
    S_TURN
  } state_e;

  localparam logic [1:0] ST_OK          = 2'd0;
  localparam logic [1:0] ST_NOT_PRESENT = 2'd1;
  localparam logic [1:0] ST_FRAME_ERR   = 2'd2;
  localparam logic [1:0] ST_TURN_ERR    = 2'd3;

  localparam int T_ATN_SETUP_US = 20;
  localparam int T_TURN_US      = 1000;

  function automatic logic [10:0] to_us(input int v);
    return 11'(v);
  endfunction

endpackage

// File: rtl/iec_us_timer.sv
// Microsecond prescaler plus saturating 11-bit elapsed-us counter.
// Both are cleared by restart.
module iec_us_timer #(
  parameter int CLK_PER_US = 32
) (
  input  logic        clk_c1541,
  input  logic        reset,
  input  logic        restart,
  output logic [10:0] us
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_US - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk_c1541) begin
    if (reset || restart) begin
      pre <= '0;
      us  <= '0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      if (us != '1)
        us <= us + 11'd1;
    end else begin
      pre <= pre + PW'(1);
    end
  end

endmodule

// File: rtl/iec_host_tx.sv
// C64-style IEC talker: command bytes under ATN, data bytes with EOI.
// Define IEC_TURNAROUND_EN to add the TALK turnaround sequence.
module iec_host_tx
  import iec_host_pkg::*;
#(
  parameter int CLK_PER_US    = 32,
  parameter int T_PRESENCE_US = 1000,
  parameter int T_FRAME_US    = 1000,
  parameter int T_EOI_US      = 250,
  parameter int T_BIT_US      = 60,
  parameter int T_BB_US       = 100
) (
  input  logic       clk_c1541,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_atn,
  input  logic       tx_eoi,
  input  logic       atn_end,
`ifdef IEC_TURNAROUND_EN
  input  logic       turnaround,
`endif
  output logic       tx_ready,
  output logic       done,
  output logic [1:0] status,
  output logic       iec_atn_o,
  output logic       iec_clk_o,
  output logic       iec_data_o,
  input  logic       iec_clk_i,
  input  logic       iec_data_i
);

  localparam logic [10:0] T_ATN    = to_us(T_ATN_SETUP_US);
  localparam logic [10:0] T_PRES   = to_us(T_PRESENCE_US);
  localparam logic [10:0] T_EOI_TO = to_us(T_EOI_US + 1000);
  localparam logic [10:0] T_BIT    = to_us(T_BIT_US);
  localparam logic [10:0] T_FRAME  = to_us(T_FRAME_US);
  localparam logic [10:0] T_BB     = to_us(T_BB_US);
  localparam logic [10:0] T_TURN   = to_us(T_TURN_US);

  state_e      state, state_n;
  logic [1:0]  clk_sync, data_sync;
  logic        clk_s, data_s;
  logic [10:0] us;
  logic        step, restart, accept;
  logic [7:0]  shreg;
  logic        eoi_q;
  logic        atn_flag, atn_flag_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic        phase, phase_n;
  logic [1:0]  status_q, status_n;
  logic        done_q, done_n;
  logic        hold_q, hold_n;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign status = status_q;
  assign done   = done_q;

`ifdef IEC_TURNAROUND_EN
  assign tx_ready = (state == S_IDLE) && !(atn_end && atn_flag)
                    && !turnaround;
`else
  assign tx_ready = (state == S_IDLE) && !(atn_end && atn_flag);
`endif

  assign accept  = tx_valid && tx_ready;
  assign restart = step || (state_n != state);

  iec_us_timer #(
    .CLK_PER_US(CLK_PER_US)
  ) u_timer (
    .clk_c1541(clk_c1541),
    .reset    (reset),
    .restart  (restart),
    .us       (us)
  );

  always_comb begin
    state_n    = state;
    atn_flag_n = atn_flag;
    bit_cnt_n  = bit_cnt;
    phase_n    = phase;
    status_n   = status_q;
    done_n     = 1'b0;
    hold_n     = hold_q;
    step       = 1'b0;
    iec_atn_o  = !atn_flag;
    iec_clk_o  = 1'b1;
    iec_data_o = 1'b1;
    unique case (state)
      S_IDLE: begin
        iec_clk_o  = !atn_flag;
        iec_data_o = !hold_q;
        if (atn_end && atn_flag)
          state_n = S_ATN_REL;
`ifdef IEC_TURNAROUND_EN
        else if (turnaround)
          state_n = S_TURN;
`endif
        else if (accept) begin
          status_n = ST_OK;
          hold_n   = 1'b0;
          state_n  = tx_atn ? S_ATN_SETUP : S_READY;
        end
      end
      S_ATN_SETUP: begin
        iec_atn_o  = 1'b0;
        iec_clk_o  = 1'b0;
        atn_flag_n = 1'b1;
        if (us >= T_ATN)
          state_n = S_PRESENCE;
      end
      S_PRESENCE: begin
        iec_clk_o = 1'b0;
        if (!data_s)
          state_n = S_READY;
        else if (us >= T_PRES) begin
          status_n = ST_NOT_PRESENT;
          state_n  = S_ABORT;
        end
      end
      S_READY: begin
        // CLK must read back released as well before clocking starts
        if (data_s && clk_s)
          state_n = eoi_q ? S_EOI_WAIT : S_CLOCKING;
      end
      S_EOI_WAIT: begin
        if (!data_s)
          state_n = S_EOI_ACK;
        else if (us >= T_EOI_TO) begin
          status_n = ST_FRAME_ERR;
          state_n  = S_ABORT;
        end
      end
      S_EOI_ACK: begin
        if (data_s)
          state_n = S_CLOCKING;
      end
      S_CLOCKING: begin
        iec_clk_o  = phase;
        iec_data_o = shreg[bit_cnt];
        if (us >= T_BIT) begin
          step = 1'b1;
          if (!phase)
            phase_n = 1'b1;
          else begin
            phase_n = 1'b0;
            if (bit_cnt == 3'd7)
              state_n = S_FRAME_ACK;
            else
              bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      S_FRAME_ACK: begin
        iec_clk_o = 1'b0;
        // skip the first us so our own last bit has left the synchroniser
        if (!data_s && us != '0) begin
          status_n = ST_OK;
          state_n  = S_GAP;
        end else if (us >= T_FRAME) begin
          status_n = ST_FRAME_ERR;
          state_n  = S_ABORT;
        end
      end
      S_GAP: begin
        iec_clk_o = 1'b0;
        if (us >= T_BB) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_ABORT: begin
        iec_atn_o  = 1'b1;
        atn_flag_n = 1'b0;
        hold_n     = 1'b0;
        done_n     = 1'b1;
        state_n    = S_IDLE;
      end
      S_ATN_REL: begin
        iec_atn_o = 1'b0;
        iec_clk_o = 1'b0;
        if (us >= T_ATN) begin
          atn_flag_n = 1'b0;
          state_n    = S_IDLE;
        end
      end
`ifdef IEC_TURNAROUND_EN
      S_TURN: begin
        iec_data_o = 1'b0;
        iec_atn_o  = (bit_cnt == 3'd0) ? 1'b0 : 1'b1;
        iec_clk_o  = (bit_cnt == 3'd2) ? 1'b1 : 1'b0;
        if (bit_cnt != 3'd2) begin
          if (us >= T_ATN) begin
            step      = 1'b1;
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else if (!clk_s && us != '0) begin
          atn_flag_n = 1'b0;
          hold_n     = 1'b1;
          status_n   = ST_OK;
          done_n     = 1'b1;
          state_n    = S_IDLE;
        end else if (us >= T_TURN) begin
          status_n = ST_TURN_ERR;
          state_n  = S_ABORT;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
    if (state_n != state) begin
      bit_cnt_n = 3'd0;
      phase_n   = 1'b0;
    end
  end

  always_ff @(posedge clk_c1541) begin
    if (reset) begin
      state     <= S_IDLE;
      atn_flag  <= 1'b0;
      bit_cnt   <= 3'd0;
      phase     <= 1'b0;
      status_q  <= ST_OK;
      done_q    <= 1'b0;
      hold_q    <= 1'b0;
      shreg     <= 8'h00;
      eoi_q     <= 1'b0;
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      state     <= state_n;
      atn_flag  <= atn_flag_n;
      bit_cnt   <= bit_cnt_n;
      phase     <= phase_n;
      status_q  <= status_n;
      done_q    <= done_n;
      hold_q    <= hold_n;
      clk_sync  <= {clk_sync[0], iec_clk_i};
      data_sync <= {data_sync[0], iec_data_i};
      if (accept) begin
        shreg <= tx_data;
        eoi_q <= tx_eoi;
      end
    end
  end

endmodule
